// File: rtl/alu_seq_unit.sv
// Sequential ALU: single-cycle logic/compare/shift ops, plus an iterative
// multiply and divide that retire one bit per clock.
module alu_seq_unit #(
   parameter int XLEN = 32,
   parameter int SHW  = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      op,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [4:0] OP_ADD    = 5'd0;
   localparam logic [4:0] OP_SUB    = 5'd1;
   localparam logic [4:0] OP_AND    = 5'd2;
   localparam logic [4:0] OP_OR     = 5'd3;
   localparam logic [4:0] OP_XOR    = 5'd4;
   localparam logic [4:0] OP_SLL    = 5'd5;
   localparam logic [4:0] OP_SRL    = 5'd6;
   localparam logic [4:0] OP_SRA    = 5'd7;
   localparam logic [4:0] OP_SLT    = 5'd8;
   localparam logic [4:0] OP_SLTU   = 5'd9;
   localparam logic [4:0] OP_MUL    = 5'd10;
   localparam logic [4:0] OP_MULH   = 5'd11;
   localparam logic [4:0] OP_MULHSU = 5'd12;
   localparam logic [4:0] OP_MULHU  = 5'd13;
   localparam logic [4:0] OP_DIV    = 5'd14;
   localparam logic [4:0] OP_DIVU   = 5'd15;
   localparam logic [4:0] OP_REM    = 5'd16;
   localparam logic [4:0] OP_REMU   = 5'd17;

   state_t            state, state_n;
   logic [4:0]        op_q;
   logic              neg_q;
   logic [SHW-1:0]    count;
   logic [XLEN-1:0]   acc_hi, acc_lo, opnd_q;
   logic [XLEN-1:0]   result_q;

   logic              accept, is_long, last_step;
   logic [SHW-1:0]    shamt;
   logic [XLEN-1:0]   quick_res;
   logic              a_neg, b_neg;
   logic [XLEN-1:0]   mag_a, mag_b, src_lo, src_d;
   logic              neg_c;
   logic [XLEN:0]     mul_sum, div_shift;
   logic [XLEN+1:0]   div_diff;
   logic              div_borrow;
   logic [XLEN-1:0]   step_hi, step_lo;
   logic [2*XLEN-1:0] prod_full;
   logic [XLEN-1:0]   quot, rem, final_res;

   assign accept    = in_valid && (state == IDLE);
   assign is_long   = (op >= OP_MUL) && (op <= OP_REMU);
   assign last_step = (count == SHW'(XLEN - 1));
   assign shamt     = operand_b[SHW-1:0];

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n   = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_n = is_long ? BUSY : DONE;
         end
         BUSY: begin
            if (last_step) state_n = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      quick_res = '0;
      case (op)
         OP_ADD:  quick_res = operand_a + operand_b;
         OP_SUB:  quick_res = operand_a - operand_b;
         OP_AND:  quick_res = operand_a & operand_b;
         OP_OR:   quick_res = operand_a | operand_b;
         OP_XOR:  quick_res = operand_a ^ operand_b;
         OP_SLL:  quick_res = operand_a << shamt;
         OP_SRL:  quick_res = operand_a >> shamt;
         OP_SRA:  quick_res = $unsigned($signed(operand_a) >>> shamt);
         OP_SLT:  quick_res = {{(XLEN-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
         OP_SLTU: quick_res = {{(XLEN-1){1'b0}}, (operand_a < operand_b)};
         default: quick_res = '0;
      endcase
   end

   // Operand setup at acceptance: acc_lo gets the multiplier or dividend,
   // opnd_q the multiplicand or divisor, neg_c the deferred sign fix-up.
   always_comb begin
      a_neg  = operand_a[XLEN-1];
      b_neg  = operand_b[XLEN-1];
      mag_a  = a_neg ? -operand_a : operand_a;
      mag_b  = b_neg ? -operand_b : operand_b;
      src_lo = operand_b;
      src_d  = operand_a;
      neg_c  = 1'b0;
      case (op)
         OP_MULH: begin
            src_lo = mag_b;
            src_d  = mag_a;
            neg_c  = a_neg ^ b_neg;
         end
         OP_MULHSU: begin
            src_lo = operand_b;
            src_d  = mag_a;
            neg_c  = a_neg;
         end
         OP_DIV: begin
            src_lo = mag_a;
            src_d  = mag_b;
            neg_c  = (a_neg ^ b_neg) && (operand_b != '0);
         end
         OP_DIVU, OP_REMU: begin
            src_lo = operand_a;
            src_d  = operand_b;
         end
         OP_REM: begin
            src_lo = mag_a;
            src_d  = mag_b;
            neg_c  = a_neg;
         end
         default: ;
      endcase
   end

   // One shift-add multiply step and one restoring divide step; borrow is
   // the two top bits so that every bit of the difference is meaningful.
   always_comb begin
      mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_q} : '0);
      div_shift  = {acc_hi, acc_lo[XLEN-1]};
      div_diff   = {1'b0, div_shift} - {2'b00, opnd_q};
      div_borrow = |div_diff[XLEN+1:XLEN];
      if (op_q >= OP_DIV) begin
         step_hi = div_borrow ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
         step_lo = {acc_lo[XLEN-2:0], ~div_borrow};
      end else begin
         step_hi = mul_sum[XLEN:1];
         step_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
      end
   end

   always_comb begin
      prod_full = {step_hi, step_lo};
      if (neg_q) prod_full = -prod_full;
      quot = neg_q ? -step_lo : step_lo;
      rem  = neg_q ? -step_hi : step_hi;
      case (op_q)
         OP_MUL:                       final_res = prod_full[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_full[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              final_res = quot;
         OP_REM, OP_REMU:              final_res = rem;
         default:                      final_res = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_q     <= '0;
         neg_q    <= 1'b0;
         count    <= '0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         opnd_q   <= '0;
         result_q <= '0;
      end else if (accept) begin
         op_q  <= op;
         count <= '0;
         if (is_long) begin
            neg_q  <= neg_c;
            acc_hi <= '0;
            acc_lo <= src_lo;
            opnd_q <= src_d;
         end else begin
            result_q <= quick_res;
         end
      end else if (state == BUSY) begin
         acc_hi <= step_hi;
         acc_lo <= step_lo;
         count  <= count + SHW'(1);
         if (last_step) result_q <= final_res;
      end
   end

   assign result = result_q;
   assign zero   = (result_q == '0);

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed and random checks of alu_seq_unit (XLEN=32) against an
// arithmetic reference model.
module tb_alu_seq_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [4:0]  op = '0;
   logic [31:0] operand_a = '0;
   logic [31:0] operand_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
   logic        zero;

   int assert_cnt = 0;
   int fail_cnt   = 0;

   alu_seq_unit #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .operand_a(operand_a), .operand_b(operand_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] model(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
      longint     sa, sb;
      logic [63:0] ua, ub, p;
      logic [4:0]  sh;
      logic        ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      sh  = b[4:0];
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f)
         5'd0:  return a + b;
         5'd1:  return a - b;
         5'd2:  return a & b;
         5'd3:  return a | b;
         5'd4:  return a ^ b;
         5'd5:  return a << sh;
         5'd6:  return a >> sh;
         5'd7:  begin p = 64'(sa >>> sh); return p[31:0]; end
         5'd8:  return (sa < sb) ? 32'd1 : 32'd0;
         5'd9:  return (ua < ub) ? 32'd1 : 32'd0;
         5'd10: begin p = ua * ub; return p[31:0]; end
         5'd11: begin p = 64'(sa * sb); return p[63:32]; end
         5'd12: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
         5'd13: begin p = ua * ub; return p[63:32]; end
         5'd14: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return a;
            p = 64'(sa / sb);
            return p[31:0];
         end
         5'd15: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         5'd16: begin
            if (b == 0) return a;
            if (ovf) return 32'd0;
            p = 64'(sa % sb);
            return p[31:0];
         end
         5'd17: return (b == 0) ? a : a % b;
         default: return 32'd0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      assert_cnt++;
      assert (obs === want) else begin
         fail_cnt++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
   endtask

   // Waits (bounded) for the unit to be idle, then presents one request for one edge.
   task automatic applyStimulus(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
      int waited = 0;
      @(negedge clk);
      while (!in_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      check("accept_ready", 32'(in_ready), 32'd1);
      in_valid  = 1'b1;
      op        = f;
      operand_a = a;
      operand_b = b;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Measures latency to out_valid, checks result/zero, applies `hold` cycles of
   // backpressure with ignored in_valid pulses, then completes the handshake.
   task automatic checkOutput(input string tag, input logic [31:0] want, input int lat_want, input int hold);
      int lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 100);
      check({tag, "_latency"}, 32'(lat), 32'(lat_want));
      check({tag, "_result"}, result, want);
      check({tag, "_zero"}, 32'(zero), 32'(want == 0));
      for (int i = 0; i < hold; i++) begin
         in_valid  = i[0];
         op        = 5'd0;
         operand_a = 32'hFF;
         operand_b = 32'h1;
         @(negedge clk);
         check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
         check({tag, "_hold_result"}, result, want);
         check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      check({tag, "_post_ready"}, 32'(in_ready), 32'd1);
      check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      logic [31:0] specials [6];
      logic [4:0]  rop;
      logic [31:0] ra, rb;
      bit          saw_valid;
      specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};

      $display("[TB] reset");
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("reset_in_ready", 32'(in_ready), 32'd1);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_result", result, 32'd0);
      check("reset_zero", 32'(zero), 32'd1);

      $display("[TB] directed operations");
      applyStimulus(5'd0, 32'd7, 32'd5);
      checkOutput("add_7_5", 32'd12, 1, 0);
      applyStimulus(5'd1, 32'd5, 32'd5);
      checkOutput("sub_5_5", 32'd0, 1, 0);
      applyStimulus(5'd11, 32'h8000_0000, 32'h8000_0000);
      checkOutput("mulh_min", 32'h4000_0000, 33, 0);
      applyStimulus(5'd10, 32'h8000_0000, 32'h8000_0000);
      checkOutput("mul_min", 32'h0, 33, 0);
      applyStimulus(5'd14, 32'h8000_0000, 32'hFFFF_FFFF);
      checkOutput("div_ovf", 32'h8000_0000, 33, 0);
      applyStimulus(5'd16, 32'h8000_0000, 32'hFFFF_FFFF);
      checkOutput("rem_ovf", 32'h0, 33, 0);
      applyStimulus(5'd15, 32'd100, 32'd0);
      checkOutput("divu_by0", 32'hFFFF_FFFF, 33, 0);
      applyStimulus(5'd17, 32'd100, 32'd0);
      checkOutput("remu_by0", 32'd100, 33, 0);
      applyStimulus(5'd14, 32'hFFFF_FFF9, 32'd2);
      checkOutput("div_m7_2", 32'hFFFF_FFFD, 33, 0);
      applyStimulus(5'd16, 32'hFFFF_FFF9, 32'd2);
      checkOutput("rem_m7_2", 32'hFFFF_FFFF, 33, 0);
      applyStimulus(5'd25, $urandom(), $urandom());
      checkOutput("op25", 32'h0, 1, 0);

      $display("[TB] backpressure");
      applyStimulus(5'd0, 32'd3, 32'd4);
      checkOutput("backpressure", 32'd7, 1, 5);

      $display("[TB] reset during BUSY");
      applyStimulus(5'd15, 32'd1000, 32'd7);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_result", result, 32'd0);
      saw_valid = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) saw_valid = 1'b1;
      end
      check("midrst_no_result", 32'(saw_valid), 32'd0);
      applyStimulus(5'd0, 32'd1, 32'd1);
      checkOutput("add_after_rst", 32'd2, 1, 0);

      $display("[TB] random operations");
      for (int i = 0; i < 80; i++) begin
         rop = 5'($urandom_range(0, 31));
         ra  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom();
         rb  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom();
         if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 40));
         applyStimulus(rop, ra, rb);
         checkOutput($sformatf("rand%0d_op%0d_a%0h_b%0h", i, rop, ra, rb),
                     model(rop, ra, rb),
                     (rop >= 5'd10 && rop <= 5'd17) ? 33 : 1,
                     $urandom_range(0, 2));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule
